gray_bin_arbiter: RTL
=====================

GRAY_BIN_ARBITER -- requirements
Module: gray_bin_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, code width in bits of each Gray input and binary output.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  4  per-requester request; requester i SHALL hold it and its data stable until accepted.
REQ-005 Port: req_data  input  4*WIDTH  Gray code for requester i at bits [i*WIDTH +: WIDTH].
REQ-006 Port: req_ready  output  4  one-hot accept; transfer for requester i occurs in a cycle with req_valid[i] and req_ready[i] both high.
REQ-007 Port: out_valid  output  1  result available.
REQ-008 Port: out_data  output  WIDTH  binary equivalent of the accepted Gray code.
REQ-009 Port: out_id  output  2  index of the requester whose code produced out_data.
REQ-010 Port: out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL share one bit-serial Gray-to-binary converter among 4 requesters using a three-state FSM: IDLE, CONV, DONE.
REQ-013 IDLE: if any req_valid bit is high, the grant SHALL go to the first valid requester searching upward from (last_grant+1) mod 4, wrapping around.
REQ-014 In that same cycle, req_ready SHALL be high for the granted requester only. The Gray code, the grant index and last_grant SHALL be captured. The FSM SHALL then move to CONV.
REQ-015 req_ready SHALL be zero in CONV and DONE, and in IDLE when no req_valid bit is set. last_grant SHALL change only on an accept.
REQ-016 CONV: a bit counter SHALL start at WIDTH-1 and produce one result bit per cycle, MSB first:
  - b[WIDTH-1] = g[WIDTH-1];
  - b[k] = b[k+1] XOR g[k] for k < WIDTH-1.
REQ-017 CONV SHALL last exactly WIDTH cycles. After the k=0 bit, the FSM SHALL move to DONE.
REQ-018 Latency: if the accept occurs in cycle T, out_valid SHALL first be high in cycle T+WIDTH+1.
REQ-019 DONE: out_valid SHALL be high. out_data and out_id SHALL be held stable until out_ready is sampled high, after which the FSM SHALL return to IDLE with out_valid low.
REQ-020 out_valid SHALL be low in IDLE and CONV. out_data SHALL be updated only during CONV.
REQ-021 Back-to-back operation: a new accept can occur no earlier than the cycle after the DONE handshake. Peak throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-022 Starvation freedom: with all 4 requesters continuously valid, grants SHALL rotate strictly 0,1,2,3,0,...
REQ-023 A requester that deasserts req_valid before being granted SHALL simply be skipped. No partial state SHALL be retained for it.

Reset
REQ-024 While rst is high at a clock edge, the following SHALL hold after that edge:
  - state = IDLE;
  - last_grant = 3, so requester 0 has first priority;
  - out_valid = 0, out_data = 0, out_id = 0, busy = 0;
  - bit counter = 0.
REQ-025 req_ready SHALL be forced to 0 in any cycle in which rst is high.
REQ-026 Reset asserted during CONV or DONE SHALL abandon the conversion. The abandoned result SHALL never be presented on out_valid.

Verification
REQ-027 Requester 0 only, g=16'h8000, out_ready=1 -> out_data=16'hFFFF, out_id=0, out_valid high exactly 17 cycles after the accept cycle, for one cycle.
REQ-028 Requester 2 with g=16'h0000, then with g=16'hFFFF -> out_data=16'h0000 then 16'hAAAA, out_id=2 both times, busy high throughout each conversion.
REQ-029 All four requesters valid continuously with distinct codes -> accept order 0,1,2,3,0. Each out_id matches its requester and each out_data matches that requester's code.
REQ-030 out_ready held low for 5 cycles in DONE, with all req_valid high -> out_valid, out_data and out_id stable for all 5 cycles; req_ready=0; the next accept occurs the cycle after out_ready goes high.
REQ-031 rst pulsed for one cycle at CONV bit 7, then requesters 0 and 3 valid -> out_valid stays 0 with no stale result, busy=0 after reset, and requester 0 is granted first.
REQ-032 Randomized requests and out_ready over at least 10000 conversions -> every out_data[i] equals the XOR of g[15:i] for the code accepted from out_id, with no lost or duplicated transfers.

Source files
------------

// File: rtl/gray_bin_arbiter.sv
// Four requesters share one bit-serial Gray-to-binary converter.
// Arbitration is round-robin, and each result is held until the consumer takes it.
module gray_bin_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_id,
  input  logic               out_ready,
  output logic               busy
);

  // Handshakes: a transfer happens on any rising edge where valid and ready are
  // both high. A producer holds valid and data stable until that edge. Ready
  // never depends on ready from the other side.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       last_grant;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_found;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] gray_q;
  logic [CW-1:0]    bit_cnt;
  logic             prev_bit;
  logic             next_bit;

  // Search upward from the requester after the last grant, wrapping mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 4'd0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready  = 4'b0001 << grant_idx;
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (bit_cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // prev_bit carries b[k+1] so the MSB step sees 0 and passes g[MSB] through.
  assign next_bit = gray_q[bit_cnt] ^ prev_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 2'd3;
      out_data   <= '0;
      out_id     <= 2'd0;
      bit_cnt    <= '0;
      gray_q     <= '0;
      prev_bit   <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_idx;
      out_id     <= grant_idx;
      gray_q     <= sel_data;
      bit_cnt    <= CW'(WIDTH - 1);
      prev_bit   <= 1'b0;
    end else if (state == CONV) begin
      out_data[bit_cnt] <= next_bit;
      prev_bit          <= next_bit;
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - CW'(1);
      end
    end
  end

endmodule
